// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU serial command path.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_AND     = 3'b000,
      OP_OR      = 3'b001,
      OP_ADD     = 3'b100,
      OP_SUB     = 3'b101,
      OP_UNKNOWN = 3'b111
   } alu_op_t;

   localparam logic DATA_T = 1'b0;
   localparam logic CMD_T  = 1'b1;

   // x^4 + x + 1, feedback taps applied after the left shift
   localparam logic [3:0] CRC4_POLY = 4'b0011;

   typedef struct packed {
      logic err_data;
      logic err_crc;
      logic err_op;
   } err_flags_t;

   typedef enum logic {
      S_IDLE,
      S_RECV
   } rx_state_t;

   function automatic logic op_legal(input logic [2:0] op);
      logic ok;
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
         default:                       ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/crc4_serial.sv
// Bit-serial CRC4 (x^4+x+1) LFSR, one bit per enabled clock; clr has priority.
module crc4_serial
   import alu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic       din,
   output logic [3:0] crc
);

   logic [3:0] crc_q, crc_d;
   logic       fb;

   always_comb begin
      fb    = crc_q[3] ^ din;
      crc_d = crc_q;
      if (clr)
         crc_d = '0;
      else if (en)
         crc_d = {crc_q[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) crc_q <= '0;
      else        crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/alu_serial_rx.sv
// Serial command receiver: deserialises data/command frames into {B,A,op},
// validates framing/count/CRC/opcode and holds the result on a valid/ready port.
module alu_serial_rx
   import alu_pkg::*;
#(
   parameter int OPERAND_BYTES = 4,
   parameter bit CRC_EN        = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sin,
   output logic [8*OPERAND_BYTES-1:0] a_out,
   output logic [8*OPERAND_BYTES-1:0] b_out,
   output logic [2:0]                 op_out,
   output logic [2:0]                 err_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       ovf
);

   localparam int W   = 8 * OPERAND_BYTES;
   localparam int NFR = 2 * OPERAND_BYTES;
   localparam int CW  = $clog2(NFR + 2);

   rx_state_t     state_q, state_d;
   logic [3:0]    bit_q, bit_d;
   logic          type_q, type_d;
   logic [7:0]    sh_q, sh_d;
   logic [2*W-1:0] ba_q, ba_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lat_q, lat_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d;
   logic [2:0]    op_q, op_d;
   err_flags_t    err_q, err_d, err_n;
   logic          vld_q, vld_d;
   logic          ovf_q, ovf_d;

   logic          crc_clr, crc_en, crc_din;
   logic [3:0]    crc_w;

   crc4_serial u_crc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (crc_clr),
      .en    (crc_en),
      .din   (crc_din),
      .crc   (crc_w)
   );

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      type_d  = type_q;
      sh_d    = sh_q;
      ba_d    = ba_q;
      cnt_d   = cnt_q;
      lat_d   = lat_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      err_d   = err_q;
      vld_d   = vld_q;
      ovf_d   = 1'b0;
      crc_clr = 1'b0;
      crc_en  = 1'b0;
      crc_din = sin;
      err_n   = '0;

      if (vld_q && out_ready)
         vld_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!sin) begin
               state_d = S_RECV;
               bit_d   = 4'd0;
            end
         end
         S_RECV: begin
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd0) begin
               type_d = sin;
            end else if (bit_q <= 4'd8) begin
               sh_d = {sh_q[6:0], sin};
               // Command frames feed a 1 in place of the leading payload
               // zero, then the opcode; the received CRC nibble is not fed.
               if (type_q == DATA_T) begin
                  crc_en = 1'b1;
               end else if (bit_q <= 4'd4) begin
                  crc_en  = 1'b1;
                  crc_din = (bit_q == 4'd1) ? 1'b1 : sin;
               end
            end else begin
               state_d = S_IDLE;
               if (!sin) begin
                  lat_d = 1'b1;
               end else if (type_q == DATA_T) begin
                  ba_d = {ba_q[2*W-9:0], sh_q};
                  if (cnt_q != CW'(NFR + 1))
                     cnt_d = cnt_q + CW'(1);
               end else begin
                  err_n.err_data = lat_q | (cnt_q != CW'(NFR));
                  err_n.err_crc  = CRC_EN & ~err_n.err_data & (crc_w != sh_q[3:0]);
                  err_n.err_op   = ~err_n.err_data & ~err_n.err_crc & ~op_legal(sh_q[6:4]);
                  cnt_d   = '0;
                  lat_d   = 1'b0;
                  crc_clr = 1'b1;
                  if (vld_q && !out_ready) begin
                     ovf_d = 1'b1;
                  end else begin
                     a_d   = ba_q[W-1:0];
                     b_d   = ba_q[2*W-1:W];
                     op_d  = sh_q[6:4];
                     err_d = err_n;
                     vld_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         bit_q   <= '0;
         type_q  <= 1'b0;
         sh_q    <= '0;
         ba_q    <= '0;
         cnt_q   <= '0;
         lat_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         err_q   <= '0;
         vld_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         type_q  <= type_d;
         sh_q    <= sh_d;
         ba_q    <= ba_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         err_q   <= err_d;
         vld_q   <= vld_d;
         ovf_q   <= ovf_d;
      end
   end

   assign a_out     = a_q;
   assign b_out     = b_q;
   assign op_out    = op_q;
   assign err_out   = err_q;
   assign out_valid = vld_q;
   assign ovf       = ovf_q;

endmodule

// File: doc/alu_serial_rx.md
Name: alu_serial_rx

Overview:
- Parametrised serial command receiver for the ALU datapath.
- Deserialises 11-bit frames from one serial line and assembles operands B and A of configurable byte width plus an opcode.
- Checks framing, frame count, CRC4 and opcode legality.
- Presents the decoded command, or error flags, on a valid/ready output towards the ALU core.

Parameters:
- OPERAND_BYTES, 4, bytes per operand; operand width W = 8*OPERAND_BYTES; each packet carries 2*OPERAND_BYTES data frames.
- CRC_EN, 1, 1 = check CRC4; 0 = CRC field ignored, err_crc never set.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sin  in  1  serial input, one bit per clk, idle high
- a_out  out  W  operand A
- b_out  out  W  operand B
- op_out  out  3  opcode
- err_out  out  3  {err_data, err_crc, err_op}
- out_valid  out  1  result/err held valid
- out_ready  in  1  consumer accepts when high with out_valid
- ovf  out  1  one-cycle pulse: completed packet dropped because the output was still occupied

Behaviour:
- Reset (async, rst_n=0) clears every output to 0, forces FSM to IDLE, and clears frame counter, shift registers, CRC and the packet error latch. A reset mid-frame or mid-packet discards everything received so far.
- Frame format: start 0, type bit (0 = data, 1 = command), 8 payload bits MSB-first, stop 1.
  - Command payload = {1'b0, op[2:0], crc[3:0]}.
- FSM states:
  - IDLE: stay while sin=1; sin=0 -> RECV and bit counter := 0.
  - RECV: shift 10 bits (type, payload, stop); after the 10th bit -> IDLE.
- Data frame, stop=1:
  - Payload is shifted into a 2W-bit register {B,A}; bytes arrive B MSB byte first, then A.
  - data_cnt increments and saturates at 2*OPERAND_BYTES+1.
- Stop bit = 0 on any frame: set the packet error latch (reported as err_data at the next command frame).
- CRC4:
  - Polynomial x^4+x+1, init 0, computed serially.
  - Per bit b: fb = crc[3]^b; crc = {crc[2:0],0} ^ (fb ? 4'b0011 : 0).
  - Updated with every payload bit of every data frame, then with 1'b1 and op[2:0] from the command frame.
  - Result is the CRC of {B,A,1'b1,op}.
- Command frame completion (stop bit sampled):
  - err_data = latch | (data_cnt != 2*OPERAND_BYTES).
  - err_crc = CRC_EN & !err_data & (computed != received crc).
  - err_op = !err_data & !err_crc & (op not in {AND 3'b000, OR 3'b001, ADD 3'b100, SUB 3'b101}).
  - Priority is data > crc > op; exactly one or zero bits set.
- Output register:
  - Loaded one clk after the command stop bit, with out_valid=1.
  - a_out/b_out/op_out are loaded even on error (don't-care when err_out != 0).
  - data_cnt, CRC and latch are cleared at the same time, ready for the next packet.
- Handshake:
  - out_valid is held, and outputs stay stable, until a clk with out_ready=1; out_valid drops the next cycle.
  - Accept and new load in the same cycle: the new load wins, out_valid stays 1.
  - Packet completes while out_valid=1 and out_ready=0: packet dropped, ovf pulses 1 clk, outputs unchanged.
- Reception never stalls: sin is sampled every clk regardless of out_ready.

Decomposition:
- alu_pkg (shared):
  - alu_op_t (AND, OR, ADD, SUB, UNKNOWN encodings)
  - frame-type constants DATA_T=0, CMD_T=1
  - CRC4 polynomial constant
  - err_flags_t packed struct {err_data, err_crc, err_op}
- Sub-module crc4_serial (clk, rst_n, clr, en, din, crc[3:0]) implements the bitwise LFSR; reused by the future serial transmitter.

Test Plan:
- OPERAND_BYTES=4; A=0, B=0, op=AND, crc=4'hB -> out_valid next clk after stop bit; a_out=0, b_out=0, op_out=000, err_out=000.
- Same packet with crc=4'hC -> err_out=3'b010 (err_crc); the following good packet decodes cleanly.
- 7 data frames then command -> err_out=3'b100. 9 data frames -> err_out=3'b100. Data frame with stop=0 then 8 data frames -> err_out=3'b100.
- A=32'hFFFF_FFFF, B=32'h0000_0001, op=3'b010 with correct CRC of {B,A,1,010} -> err_out=3'b001.
- Hold out_ready=0, send two good packets -> first packet stays on outputs, ovf pulses once after the second command stop; out_ready=1 -> out_valid falls next clk.
- rst_n low for 1 clk midway through the 5th data frame, then a full good packet with A=32'h1234_5678, B=32'h9ABC_DEF0, op=ADD -> only the post-reset packet is reported, with err_out=000 and exact operands. Repeat the good-packet case with OPERAND_BYTES=1.
